spmc_spi_slave: RTL and testbench

//  SPI slave (mode 0, MSB first, 8-bit frames) peripheral on the SpartanMC peripheral bus; the counterpart of the
//  SD-card SPI master. Lets an external SPI master exchange bytes with firmware via RX/TX FIFOs. All SPI inputs are

---
 rtl/spmc_spi_slave_pkg.sv | 26 ++
 rtl/spmc_spi_slave_fifo.sv | 57 +++++
 rtl/spmc_spi_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_spmc_spi_slave.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmc_spi_slave_pkg.sv
// Shared definitions for the SpartanMC SPI slave: register offsets, STATUS/CTRL bit positions, slave FSM states.
package spmc_spi_slave_pkg;

  localparam logic [5:0] REG_DATA     = 6'd0;
  localparam logic [5:0] REG_STATUS   = 6'd1;
  localparam logic [5:0] REG_CTRL     = 6'd2;
  localparam logic [5:0] REG_IRQ_MASK = 6'd3;

  localparam int ST_RX_EMPTY  = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_UNDERRUN  = 5;
  localparam int ST_CS_ACTIVE = 6;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } slave_state_t;

endpackage

// File: rtl/spmc_spi_slave_fifo.sv
// Synchronous byte FIFO with flush; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module spi_slave_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [W-1:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_ONE;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/spmc_spi_slave.sv
// SPI slave (mode 0, MSB first, 8-bit) on the SpartanMC peripheral bus, SPI pins oversampled in clk_peri.
// Optional interrupt output and IRQ_MASK register are built when SPI_SLAVE_IRQ_EN is defined.
module spmc_spi_slave
  import spmc_spi_slave_pkg::*;
#(
  parameter logic [9:0] BASE_ADR        = 10'h0,
  parameter int         FIFO_DEPTH_LOG2 = 3,
  parameter logic [7:0] FILL_BYTE       = 8'hFF
) (
  input  logic        clk_peri,
  input  logic        reset_n,
  input  logic [17:0] do_peri,
  output logic [17:0] di_peri,
  input  logic [9:0]  addr_peri,
  input  logic        access_peri,
  input  logic        wr_peri,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic        irq
`endif
);

  slave_state_t r_state, w_next;
  logic [1:0]  r_sclk_s, r_mosi_s, r_cs_s;
  logic        r_sclk_prev, r_cs_prev;
  logic [7:0]  r_shift_tx, r_shift_rx;
  logic [2:0]  r_bit_cnt;
  logic        r_underrun, r_overrun, r_enable;
  logic [17:0] r_di;

  logic        w_sclk, w_mosi, w_cs_n, w_sclk_rise, w_sclk_fall, w_cs_fall;
  logic        w_sel, w_wr, w_rd;
  logic [5:0]  w_reg;
  logic        w_cpu_tx_push, w_cpu_rx_pop, w_flush, w_clr_under, w_clr_over;
  logic        w_load_tx, w_shift_tx, w_shift_rx, w_rx_push, w_spi_tx_pop;
  logic        w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic [7:0]  w_rx_head, w_tx_head;
  logic [6:0]  w_status;
  logic [17:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^do_peri[17:8];

  always_ff @(posedge clk_peri or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_s    <= 2'b00;
      r_mosi_s    <= 2'b00;
      r_cs_s      <= 2'b11;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_s    <= {r_sclk_s[0], spi_sclk};
      r_mosi_s    <= {r_mosi_s[0], spi_mosi};
      r_cs_s      <= {r_cs_s[0], spi_cs_n};
      r_sclk_prev <= r_sclk_s[1];
      r_cs_prev   <= r_cs_s[1];
    end
  end

  assign w_sclk      = r_sclk_s[1];
  assign w_mosi      = r_mosi_s[1];
  assign w_cs_n      = r_cs_s[1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_cs_fall   = ~w_cs_n & r_cs_prev;

  assign w_sel         = access_peri & (addr_peri[9:6] == BASE_ADR[9:6]);
  assign w_wr          = w_sel & wr_peri;
  assign w_rd          = w_sel & ~wr_peri;
  assign w_reg         = addr_peri[5:0];
  assign w_cpu_tx_push = w_wr & (w_reg == REG_DATA);
  assign w_cpu_rx_pop  = w_rd & (w_reg == REG_DATA) & ~w_rx_empty;
  assign w_flush       = w_wr & (w_reg == REG_CTRL) & do_peri[CTRL_FLUSH];
  assign w_clr_under   = w_wr & (w_reg == REG_STATUS) & do_peri[ST_UNDERRUN];
  assign w_clr_over    = w_wr & (w_reg == REG_STATUS) & do_peri[ST_OVERRUN];

  always_ff @(posedge clk_peri or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // A falling sclk with bit_cnt==0 ends a byte and fetches the next TX byte, exactly like LOAD.
  always_comb begin
    w_next     = r_state;
    w_load_tx  = 1'b0;
    w_shift_tx = 1'b0;
    w_shift_rx = 1'b0;
    w_rx_push  = 1'b0;
    case (r_state)
      S_IDLE: if (r_enable && w_cs_fall) w_next = S_LOAD;
      S_LOAD: begin
        if (!r_enable || w_cs_n) begin
          w_next = S_IDLE;
        end else begin
          w_load_tx = 1'b1;
          w_next    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!r_enable || w_cs_n) begin
          w_next = S_IDLE;
        end else if (w_sclk_rise) begin
          w_shift_rx = 1'b1;
          w_rx_push  = (r_bit_cnt == 3'd7);
        end else if (w_sclk_fall) begin
          if (r_bit_cnt == 3'd0) w_load_tx  = 1'b1;
          else                   w_shift_tx = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_spi_tx_pop = w_load_tx & ~w_tx_empty;

  always_ff @(posedge clk_peri or negedge reset_n) begin
    if (!reset_n) begin
      r_shift_tx <= '0;
      r_shift_rx <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE) r_bit_cnt <= '0;
      if (w_load_tx) begin
        r_shift_tx <= w_tx_empty ? FILL_BYTE : w_tx_head;
        r_bit_cnt  <= '0;
      end else if (w_shift_tx) begin
        r_shift_tx <= {r_shift_tx[6:0], 1'b0};
      end
      if (w_shift_rx) begin
        r_shift_rx <= {r_shift_rx[6:0], w_mosi};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
    end
  end

  // Sticky flags: a set in the same cycle as a CPU clear wins.
  always_ff @(posedge clk_peri or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
      r_enable   <= 1'b0;
    end else begin
      r_underrun <= (w_load_tx & w_tx_empty) | (r_underrun & ~w_clr_under);
      r_overrun  <= (w_rx_push & w_rx_full & ~w_cpu_rx_pop) | (r_overrun & ~w_clr_over);
      if (w_wr && (w_reg == REG_CTRL)) r_enable <= do_peri[CTRL_ENABLE];
    end
  end

  spi_slave_fifo #(.W(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .i_clk   (clk_peri),
    .i_rst_n (reset_n),
    .i_flush (w_flush),
    .i_push  (w_rx_push),
    .i_data  ({r_shift_rx[6:0], w_mosi}),
    .i_pop   (w_cpu_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  spi_slave_fifo #(.W(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .i_clk   (clk_peri),
    .i_rst_n (reset_n),
    .i_flush (w_flush),
    .i_push  (w_cpu_tx_push),
    .i_data  (do_peri[7:0]),
    .i_pop   (w_spi_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

`ifdef SPI_SLAVE_IRQ_EN
  logic [3:0] r_irq_mask;
  logic       r_irq;

  always_ff @(posedge clk_peri or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (w_reg == REG_IRQ_MASK)) r_irq_mask <= do_peri[3:0];
      r_irq <= |(r_irq_mask & {r_underrun, r_overrun, w_tx_empty, ~w_rx_empty});
    end
  end

  assign irq = r_irq;
`endif

  always_comb begin
    w_status               = '0;
    w_status[ST_RX_EMPTY]  = w_rx_empty;
    w_status[ST_RX_FULL]   = w_rx_full;
    w_status[ST_TX_EMPTY]  = w_tx_empty;
    w_status[ST_TX_FULL]   = w_tx_full;
    w_status[ST_OVERRUN]   = r_overrun;
    w_status[ST_UNDERRUN]  = r_underrun;
    w_status[ST_CS_ACTIVE] = ~w_cs_n;
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_DATA:     w_rdata = w_rx_empty ? 18'h0 : {10'h0, w_rx_head};
      REG_STATUS:   w_rdata = {11'h0, w_status};
      REG_CTRL:     w_rdata = {17'h0, r_enable};
`ifdef SPI_SLAVE_IRQ_EN
      REG_IRQ_MASK: w_rdata = {14'h0, r_irq_mask};
`else
      REG_IRQ_MASK: w_rdata = '0;
`endif
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_peri or negedge reset_n) begin
    if (!reset_n) r_di <= '0;
    else          r_di <= w_rd ? w_rdata : 18'h0;
  end

  assign di_peri     = r_di;
  assign spi_miso    = (r_state == S_SHIFT) ? r_shift_tx[7] : 1'b0;
  assign spi_miso_oe = (r_state != S_IDLE);

endmodule

// File: tb/tb_spmc_spi_slave.sv
// Bench for spmc_spi_slave: queue-based model of the FIFOs/flags, SPI mode-0 master driver, per-cycle di_peri check.
module tb_spmc_spi_slave;

  localparam int HALF = 80;

  logic        clk_peri = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] do_peri = '0;
  logic [17:0] di_peri;
  logic [9:0]  addr_peri = '0;
  logic        access_peri = 1'b0;
  logic        wr_peri = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_miso;
  logic        spi_miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
  logic        irq;
`endif

  always #5 clk_peri = ~clk_peri;

  spmc_spi_slave u_dut (
    .clk_peri    (clk_peri),
    .reset_n     (reset_n),
    .do_peri     (do_peri),
    .di_peri     (di_peri),
    .addr_peri   (addr_peri),
    .access_peri (access_peri),
    .wr_peri     (wr_peri),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
`ifdef SPI_SLAVE_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [17:0] exp_q[$];
  logic [7:0]  m_rx[$];
  logic [7:0]  m_tx[$];
  logic [7:0]  mosi_q[$];
  logic [7:0]  miso_got[$];
  logic        m_under = 1'b0;
  logic        m_over = 1'b0;
  logic        m_en = 1'b0;
  logic [3:0]  m_mask = '0;
  logic [17:0] act;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] m_status();
    return {11'h0, 1'b0, m_under, m_over, m_tx.size() == 8, m_tx.size() == 0,
            m_rx.size() == 8, m_rx.size() == 0};
  endfunction

  function automatic void m_reset();
    m_rx.delete();
    m_tx.delete();
    m_under = 1'b0;
    m_over  = 1'b0;
    m_en    = 1'b0;
    m_mask  = '0;
  endfunction

  // Every cycle: di_peri carries the expected read data one cycle after a selected read, else zero.
  initial begin
    logic was_rd;
    forever begin
      @(posedge clk_peri);
      was_rd = access_peri && !wr_peri && (addr_peri[9:6] == 4'h0);
      @(negedge clk_peri);
      if (was_rd) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL di_unexpected_read: got 0x%0h expected none", di_peri);
        end else begin
          check("di_read", di_peri, exp_q.pop_front());
        end
      end else begin
        check("di_idle", di_peri, 18'h0);
      end
    end
  end

  task automatic bus_cycle(input logic [9:0] a, input logic w, input logic [17:0] d);
    @(posedge clk_peri); #1;
    access_peri = 1'b1; wr_peri = w; addr_peri = a; do_peri = d;
    @(posedge clk_peri); #1;
    access_peri = 1'b0; wr_peri = 1'b0; addr_peri = '0; do_peri = '0;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [17:0] d);
    case (a)
      6'd0: if (m_tx.size() < 8) m_tx.push_back(d[7:0]);
      6'd1: begin
        if (d[5]) m_under = 1'b0;
        if (d[4]) m_over = 1'b0;
      end
      6'd2: begin
        m_en = d[0];
        if (d[1]) begin m_rx.delete(); m_tx.delete(); end
      end
`ifdef SPI_SLAVE_IRQ_EN
      6'd3: m_mask = d[3:0];
`endif
      default: ;
    endcase
    bus_cycle({4'h0, a}, 1'b1, d);
  endtask

  task automatic cpu_read(input logic [5:0] a, output logic [17:0] got);
    logic [17:0] e;
    e = '0;
    case (a)
      6'd0: if (m_rx.size() > 0) e = {10'h0, m_rx.pop_front()};
      6'd1: e = m_status();
      6'd2: e = {17'h0, m_en};
`ifdef SPI_SLAVE_IRQ_EN
      6'd3: e = {14'h0, m_mask};
`endif
      default: e = '0;
    endcase
    exp_q.push_back(e);
    bus_cycle({4'h0, a}, 1'b0, 18'h0);
    @(negedge clk_peri);
    got = di_peri;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    #(HALF);
    m = spi_miso;
    spi_sclk = 1'b1;
    #(HALF);
    spi_sclk = 1'b0;
  endtask

  // One chip-select session: n_full whole bytes then k_part bits of an abandoned byte.
  task automatic spi_session(input int n_full, input int k_part);
    logic [7:0] exp_miso[$];
    logic [7:0] mb, got, e;
    logic       m;
    int         nb, nbytes;
    if (m_en) begin
      for (int i = 0; i <= n_full; i++) begin
        if (m_tx.size() > 0) exp_miso.push_back(m_tx.pop_front());
        else begin exp_miso.push_back(8'hFF); m_under = 1'b1; end
      end
    end
    miso_got.delete();
    nbytes = n_full + ((k_part > 0) ? 1 : 0);
    @(posedge clk_peri); #2;
    spi_cs_n = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      mb  = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'($urandom);
      nb  = (i < n_full) ? 8 : k_part;
      got = '0;
      for (int b = 0; b < nb; b++) begin
        spi_bit(mb[7-b], m);
        got = {got[6:0], m};
        if (i == 0 && b == 0) check("miso_oe_active", spi_miso_oe, m_en);
      end
      miso_got.push_back(got);
      e = 8'h00;
      if (m_en) e = exp_miso[i];
      if (i < n_full) begin
        check("miso_byte", got, e);
        if (m_en) begin
          if (m_rx.size() < 8) m_rx.push_back(mb);
          else m_over = 1'b1;
        end
      end else begin
        check("miso_partial", got, e >> (8 - k_part));
      end
    end
    #(HALF);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (8) @(posedge clk_peri);
    check("miso_oe_idle", spi_miso_oe, 1'b0);
    check("miso_idle", spi_miso, 1'b0);
  endtask

  initial begin
    logic m;
    int   n, nf, kp;
    repeat (4) @(posedge clk_peri);
    check("reset_miso_oe", spi_miso_oe, 1'b0);
    check("reset_miso", spi_miso, 1'b0);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk_peri);

    cpu_read(6'd1, act);
    check("pin_reset_status", act, 18'h05);
    cpu_write(6'd2, 18'h1);
    cpu_read(6'd2, act);
    check("pin_ctrl_enable", act, 18'h1);

    cpu_write(6'd0, 18'hA5);
    mosi_q.push_back(8'h3C);
    spi_session(1, 0);
    check("pin_miso_a5", miso_got[0], 8'hA5);
    cpu_read(6'd0, act);
    check("pin_rx_3c", act, 18'h3C);
    cpu_write(6'd1, 18'h20);

    spi_session(1, 0);
    check("pin_miso_fill", miso_got[0], 8'hFF);
    cpu_read(6'd1, act);
    check("pin_underrun_set", act[5], 1'b1);
    cpu_write(6'd1, 18'h20);
    cpu_read(6'd1, act);
    check("pin_underrun_clr", act[5], 1'b0);
    cpu_read(6'd0, act);

    for (int i = 0; i < 9; i++) mosi_q.push_back(8'h10 + 8'(i));
    spi_session(9, 0);
    cpu_read(6'd1, act);
    check("pin_overrun_set", act[4], 1'b1);
    check("pin_rx_full", act[1], 1'b1);
    for (int i = 0; i < 8; i++) begin
      cpu_read(6'd0, act);
      check("pin_rx_order", act, 18'h10 + 18'(i));
    end
    cpu_read(6'd0, act);
    check("pin_rx_empty_read", act, 18'h0);
    cpu_write(6'd1, 18'h30);

    spi_session(0, 4);
    cpu_read(6'd1, act);
    check("pin_abort_rx_empty", act[0], 1'b1);
    mosi_q.push_back(8'h5A);
    spi_session(1, 0);
    cpu_read(6'd0, act);
    check("pin_after_abort", act, 18'h5A);

    cpu_write(6'd2, 18'h0);
    spi_session(1, 0);
    cpu_read(6'd1, act);
    cpu_write(6'd2, 18'h1);
    bus_cycle(10'h041, 1'b0, 18'h0);
    cpu_read(6'd3, act);
    cpu_read(6'd7, act);

    cpu_write(6'd0, 18'h11);
    cpu_write(6'd0, 18'h22);
    cpu_write(6'd2, 18'h3);
    cpu_read(6'd1, act);
    check("pin_flush_tx_empty", act[2], 1'b1);

    for (int it = 0; it < 50; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          n = $urandom_range(1, 4);
          for (int j = 0; j < n; j++) cpu_write(6'd0, 18'($urandom_range(0, 255)));
        end
        1: begin
          nf = $urandom_range(0, 3);
          if (nf == 0) kp = $urandom_range(1, 7);
          else kp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
          spi_session(nf, kp);
        end
        2: begin
          n = $urandom_range(1, 5);
          for (int j = 0; j < n; j++) cpu_read(6'd0, act);
        end
        3: cpu_read(6'd1, act);
        4: cpu_write(6'd1, 18'($urandom_range(0, 63)));
        default: begin
          if ($urandom_range(0, 3) == 0) cpu_write(6'd2, 18'h3);
          else cpu_read(6'd2, act);
        end
      endcase
    end

    cpu_write(6'd0, 18'h77);
    @(posedge clk_peri); #2;
    spi_cs_n = 1'b0;
    for (int b = 0; b < 4; b++) spi_bit(1'b1, m);
    reset_n = 1'b0;
    #1;
    check("reset_mid_miso_oe", spi_miso_oe, 1'b0);
    check("reset_mid_miso", spi_miso, 1'b0);
    m_reset();
    spi_cs_n = 1'b1;
    repeat (4) @(posedge clk_peri);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk_peri);
    cpu_read(6'd1, act);
    check("pin_reset_mid_status", act, 18'h05);

`ifdef SPI_SLAVE_IRQ_EN
    cpu_write(6'd2, 18'h1);
    cpu_write(6'd3, 18'h1);
    spi_session(1, 0);
    repeat (3) @(posedge clk_peri);
    check("irq_rx_set", irq, 1'b1);
    cpu_read(6'd0, act);
    repeat (3) @(posedge clk_peri);
    check("irq_rx_clr", irq, 1'b0);
`endif

    repeat (4) @(posedge clk_peri);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
